async_fifo_rd_port: RTL and testbench
=====================================

// Module: async_fifo_rd_port
// PURPOSE
//  Read-side port of the dual-clock FIFO. Runs in the consumer clock domain and pairs with the
//  write-side pointer logic. Synchronises the write gray pointer, owns the read pointer and
//  drives the RAM read address. Absorbs the 1-cycle RAM read latency in a 2-entry output buffer
//  and presents words on a valid/ready stream that sustains 1 word/cycle.
// PARAMETERS
//  fifo_data_size    8  RAM word width (bits)
//  fifo_ptr_size     8  log2 RAM depth; pointers are fifo_ptr_size+1 bits
//  almost_empty_thr  4  almost_empty asserts while rd_level < this value
// PORTS
//  clk           in   1       consumer clock; single clock domain
//  reset_n       in   1       asynchronous, active-low reset
//  wr_ptr_gray   in   P+1     write pointer (gray), from write domain, unsynchronised (P=fifo_ptr_size)
//  rd_ptr_gray   out  P+1     registered read pointer (gray), to write domain
//  mem_rd_en     out  1       RAM read strobe
//  mem_rd_addr   out  P       RAM read address = rd_cnt[P-1:0]
//  mem_rd_data   in   D       RAM data, valid the cycle after mem_rd_en (D=fifo_data_size)
//  out_data      out  D       head word of output buffer
//  out_valid     out  1       out_data valid
//  out_ready     in   1       consumer accepts; pop = out_valid & out_ready
//  fifo_empty    out  1       registered: RAM, in-flight read and buffer all empty
//  rd_level      out  P+2     registered word count (RAM unread + in-flight + buffered)
//  almost_empty  out  1       registered: rd_level < almost_empty_thr
// BEHAVIOUR
//  - Reset (async, reset_n=0): sync regs, rd_cnt, pend, buffer cleared; rd_ptr_gray=0, out_valid=0,
//    out_data=0, fifo_empty=1, rd_level=0, almost_empty=1; mem_rd_en=0 follows from equal pointers.
//  - Sync: wr_ptr_gray -> sync1 -> sync2 (two flops). wr_bin = gray2bin(sync2), combinational.
//  - avail = (wr_bin != rd_cnt). Equal upper and lower bits = empty; a difference of 2^P
//    (RAM full) counts as avail.
//  - Credit rule: mem_rd_en = avail & (buf_cnt + pend - pop < 2). pend <= mem_rd_en.
//  - rd_cnt (P+1 bits) increments on mem_rd_en and wraps 2^(P+1)-1 -> 0.
//    rd_ptr_gray <= bin2gray(rd_cnt_next) on the same edge.
//  - When pend=1, mem_rd_data is written into the buffer at that edge.
//  - Buffer is a 2-deep FIFO with registered head:
//    - out_data/out_valid come from the head.
//    - Push and pop in the same cycle: buf_cnt unchanged, order preserved.
//    - out_ready ignored while out_valid=0.
//    - out_data stable while out_valid & !out_ready.
//  - Latency: E0 is the first edge that samples a new wr_ptr_gray.
//    - mem_rd_en is high in the cycle after E1 (rd_cnt increments at E2).
//    - RAM data is captured and out_valid rises at E3.
//  - Throughput: with out_ready held high, 1 word/cycle steady state (buf_cnt=1, pend=1).
//  - rd_level <= ((wr_bin_nxt - rd_cnt_nxt) mod 2^(P+1)) + buf_cnt_nxt + pend_nxt, in P+2 bits.
//    - wr_bin_nxt = gray2bin(sync1).
//    - Maximum value is 2^P+2: RAM refilled while the buffer holds 2 words.
//  - fifo_empty <= (rd_level_nxt == 0). almost_empty <= (rd_level_nxt < almost_empty_thr).
//  - Reset mid-operation clears all state immediately. Buffered and in-flight words are discarded.
//    The write side must be reset in the same event.
// TESTING
//  1 Reset: reset_n=0 with wr_ptr_gray=9'h1FF.
//    -> all outputs at reset values; after release with wr_ptr_gray=0, no mem_rd_en for 20 cycles.
//  2 Single word: wr_ptr_gray 0->1, RAM returns 8'hA5.
//    -> one mem_rd_en with addr 0; out_valid and out_data=A5 at E3; rd_ptr_gray=1;
//    -> fifo_empty=1 one edge after the pop.
//  3 Backpressure: 10 words, out_ready=0.
//    -> exactly 2 mem_rd_en; out_data holds word0; rd_level=10.
//    -> then out_ready=1: words 0..9 in order, 1 per cycle.
//  4 Wrap: P=4, stream 100 words, out_ready=1.
//    -> 1 word/cycle after latency; rd_cnt wraps 31->0; each rd_ptr_gray step flips 1 bit; data in order.
//  5 Full: P=4, writer fills 16 words, out_ready=0.
//    -> rd_level=16; refill 2 more after rd_ptr_gray advances -> rd_level=18; almost_empty=0.
//  6 Async reset mid-stream, 8 words pending.
//    -> out_valid=0 and rd_ptr_gray=0 with no clock edge; no spurious mem_rd_en after release.

Source files
------------

// File: rtl/async_fifo_rd_port.sv
// Read-side port of a dual-clock FIFO: synchronises the write gray pointer,
// owns the read pointer, issues RAM reads and hides the 1-cycle RAM latency
// behind a 2-entry output buffer feeding a valid/ready stream.
module async_fifo_rd_port #(
    parameter int unsigned fifo_data_size   = 8,
    parameter int unsigned fifo_ptr_size    = 8,
    parameter int unsigned almost_empty_thr = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [fifo_ptr_size:0]    wr_ptr_gray,
    output logic [fifo_ptr_size:0]    rd_ptr_gray,
    output logic                      mem_rd_en,
    output logic [fifo_ptr_size-1:0]  mem_rd_addr,
    input  logic [fifo_data_size-1:0] mem_rd_data,
    output logic [fifo_data_size-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      fifo_empty,
    output logic [fifo_ptr_size+1:0]  rd_level,
    output logic                      almost_empty
);

    localparam int unsigned ptr_w  = fifo_ptr_size + 1;
    localparam int unsigned lvl_w  = fifo_ptr_size + 2;
    localparam int unsigned data_w = fifo_data_size;

    function automatic logic [ptr_w-1:0] gray2bin(input logic [ptr_w-1:0] g);
        logic [ptr_w-1:0] b;
        b = g;
        for (int i = int'(ptr_w) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [ptr_w-1:0] bin2gray(input logic [ptr_w-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [ptr_w-1:0]  sync1, sync2;
    logic [ptr_w-1:0]  rd_cnt;
    logic              pend;
    logic [1:0]        buf_cnt;
    logic [data_w-1:0] buf_head, buf_tail;

    logic [ptr_w-1:0]  wr_bin, wr_bin_nxt, rd_cnt_nxt, ram_words;
    logic              avail, pop;
    logic [2:0]        occ;
    logic [1:0]        cnt_nxt;
    logic [data_w-1:0] head_nxt, tail_nxt;
    logic [lvl_w-1:0]  lvl_nxt;

    // Two-flop synchroniser for the write pointer coming from the other clock domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= wr_ptr_gray;
            sync2 <= sync1;
        end
    end

    // Read issue: only fetch when the buffer will have room for the returning word
    always_comb begin
        wr_bin     = gray2bin(sync2);
        wr_bin_nxt = gray2bin(sync1);
        avail      = (wr_bin != rd_cnt);
        pop        = out_valid & out_ready;
        occ        = {1'b0, buf_cnt} + {2'b00, pend};
        mem_rd_en  = avail && (occ < (3'd2 + {2'b00, pop}));
        rd_cnt_nxt = rd_cnt + ptr_w'(mem_rd_en);
    end

    assign mem_rd_addr = rd_cnt[fifo_ptr_size-1:0];
    assign out_data    = buf_head;

    // Output buffer next state: push from the RAM return, pop to the consumer
    always_comb begin
        head_nxt = buf_head;
        tail_nxt = buf_tail;
        cnt_nxt  = buf_cnt;
        case ({pend, pop})
            2'b10: begin
                if (buf_cnt == 2'd0) head_nxt = mem_rd_data;
                else                 tail_nxt = mem_rd_data;
                cnt_nxt = buf_cnt + 2'd1;
            end
            2'b01: begin
                head_nxt = buf_tail;
                cnt_nxt  = buf_cnt - 2'd1;
            end
            2'b11: begin
                if (buf_cnt == 2'd1) begin
                    head_nxt = mem_rd_data;
                end else begin
                    head_nxt = buf_tail;
                    tail_nxt = mem_rd_data;
                end
            end
            default: ;
        endcase
    end

    // Occupancy seen after this edge: unread RAM words plus in-flight plus buffered
    always_comb begin
        ram_words = wr_bin_nxt - rd_cnt_nxt;
        lvl_nxt   = lvl_w'(ram_words) + lvl_w'(cnt_nxt) + lvl_w'(mem_rd_en);
    end

    // Read pointer, in-flight flag, buffer and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt       <= '0;
            rd_ptr_gray  <= '0;
            pend         <= 1'b0;
            buf_cnt      <= 2'd0;
            buf_head     <= '0;
            buf_tail     <= '0;
            out_valid    <= 1'b0;
            fifo_empty   <= 1'b1;
            rd_level     <= '0;
            almost_empty <= 1'b1;
        end else begin
            rd_cnt       <= rd_cnt_nxt;
            rd_ptr_gray  <= bin2gray(rd_cnt_nxt);
            pend         <= mem_rd_en;
            buf_cnt      <= cnt_nxt;
            buf_head     <= head_nxt;
            buf_tail     <= tail_nxt;
            out_valid    <= (cnt_nxt != 2'd0);
            fifo_empty   <= (lvl_nxt == '0);
            rd_level     <= lvl_nxt;
            almost_empty <= (lvl_nxt < lvl_w'(almost_empty_thr));
        end
    end

endmodule

// File: tb/tb_async_fifo_rd_port.sv
// Bench for async_fifo_rd_port: two instances (P=8 and P=4) with behavioural
// write side and RAM; read data is scoreboarded against the written words.
module tb_async_fifo_rd_port;

    localparam int unsigned PA = 8;
    localparam int unsigned PB = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [PA:0]   wr_ptr_gray_a, rd_ptr_gray_a;
    logic          mem_rd_en_a, out_valid_a, out_ready_a, fifo_empty_a, almost_empty_a;
    logic [PA-1:0] mem_rd_addr_a;
    logic [7:0]    mem_rd_data_a, out_data_a;
    logic [PA+1:0] rd_level_a;

    logic [PB:0]   wr_ptr_gray_b, rd_ptr_gray_b;
    logic          mem_rd_en_b, out_valid_b, out_ready_b, fifo_empty_b, almost_empty_b;
    logic [PB-1:0] mem_rd_addr_b;
    logic [7:0]    mem_rd_data_b, out_data_b;
    logic [PB+1:0] rd_level_b;

    async_fifo_rd_port #(.fifo_data_size(8), .fifo_ptr_size(PA), .almost_empty_thr(4)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .wr_ptr_gray(wr_ptr_gray_a), .rd_ptr_gray(rd_ptr_gray_a),
        .mem_rd_en(mem_rd_en_a), .mem_rd_addr(mem_rd_addr_a), .mem_rd_data(mem_rd_data_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .fifo_empty(fifo_empty_a), .rd_level(rd_level_a), .almost_empty(almost_empty_a));

    async_fifo_rd_port #(.fifo_data_size(8), .fifo_ptr_size(PB), .almost_empty_thr(4)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .wr_ptr_gray(wr_ptr_gray_b), .rd_ptr_gray(rd_ptr_gray_b),
        .mem_rd_en(mem_rd_en_b), .mem_rd_addr(mem_rd_addr_b), .mem_rd_data(mem_rd_data_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .fifo_empty(fifo_empty_b), .rd_level(rd_level_b), .almost_empty(almost_empty_b));

    logic [7:0] ram_a [2**PA];
    logic [7:0] ram_b [2**PB];
    logic [PA:0] wp_a;
    logic [PB:0] wp_b;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    int vectors = 0;
    int miscompares = 0;

    // Synchronous-read RAM models
    always @(posedge clk) if (mem_rd_en_a) mem_rd_data_a <= ram_a[mem_rd_addr_a];
    always @(posedge clk) if (mem_rd_en_b) mem_rd_data_b <= ram_b[mem_rd_addr_b];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PB:0] g2b_b(input logic [PB:0] g);
        logic [PB:0] b;
        b = g;
        for (int i = int'(PB) - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic write_a(input logic [7:0] d);
        ram_a[wp_a[PA-1:0]] = d;
        wp_a = wp_a + 1'b1;
        wr_ptr_gray_a = wp_a ^ (wp_a >> 1);
        q_a.push_back(d);
    endtask

    task automatic write_b(input logic [7:0] d);
        ram_b[wp_b[PB-1:0]] = d;
        wp_b = wp_b + 1'b1;
        wr_ptr_gray_b = wp_b ^ (wp_b >> 1);
        q_b.push_back(d);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: read-address order, scoreboard pops, gray stepping and wraps
    int cyc = 0, rd_en_a = 0, rd_en_b = 0, pops_b = 0, first_pop_b = 0, last_pop_b = 0, wraps_b = 0;
    logic [PA:0] exp_addr_a;
    logic [PB:0] exp_addr_b, prev_g_b;
    logic [31:0] exp_w;
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            exp_addr_a = '0;
            exp_addr_b = '0;
            prev_g_b   = '0;
        end else begin
            if (mem_rd_en_a) begin
                rd_en_a++;
                check("rd_addr_a", 32'(mem_rd_addr_a), 32'(exp_addr_a[PA-1:0]));
                exp_addr_a = exp_addr_a + 1'b1;
            end
            if (mem_rd_en_b) begin
                rd_en_b++;
                check("rd_addr_b", 32'(mem_rd_addr_b), 32'(exp_addr_b[PB-1:0]));
                exp_addr_b = exp_addr_b + 1'b1;
            end
            if (out_valid_a && out_ready_a) begin
                exp_w = (q_a.size() != 0) ? 32'(q_a.pop_front()) : 32'hFFFF_FFFF;
                check("data_a", 32'(out_data_a), exp_w);
            end
            if (out_valid_b && out_ready_b) begin
                exp_w = (q_b.size() != 0) ? 32'(q_b.pop_front()) : 32'hFFFF_FFFF;
                check("data_b", 32'(out_data_b), exp_w);
                if (pops_b == 0) first_pop_b = cyc;
                last_pop_b = cyc;
                pops_b++;
            end
            if (rd_ptr_gray_b != prev_g_b) begin
                check("gray_step_b", 32'($countones(rd_ptr_gray_b ^ prev_g_b)), 32'd1);
                if (prev_g_b == 5'b10000 && rd_ptr_gray_b == 5'b00000) wraps_b++;
                prev_g_b = rd_ptr_gray_b;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int base, n, pb0;
    initial begin
        // 1: reset with a nonzero write pointer present
        reset_n = 1'b0;
        wp_a = '0; wp_b = '0;
        wr_ptr_gray_a = 9'h1FF;
        wr_ptr_gray_b = '0;
        out_ready_a = 1'b0; out_ready_b = 1'b0;
        tick(3);
        check("rst_rd_ptr_gray", 32'(rd_ptr_gray_a), 32'd0);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_out_data", 32'(out_data_a), 32'd0);
        check("rst_fifo_empty", 32'(fifo_empty_a), 32'd1);
        check("rst_rd_level", 32'(rd_level_a), 32'd0);
        check("rst_almost_empty", 32'(almost_empty_a), 32'd1);
        check("rst_mem_rd_en", 32'(mem_rd_en_a), 32'd0);
        wr_ptr_gray_a = '0;
        tick(1);
        reset_n = 1'b1;
        base = rd_en_a;
        tick(20);
        check("idle_rd_en", 32'(rd_en_a - base), 32'd0);

        // 2: single word latency
        write_a(8'hA5);
        tick(1);
        check("lat_e0_rd_en", 32'(mem_rd_en_a), 32'd0);
        tick(1);
        check("lat_e1_rd_en", 32'(mem_rd_en_a), 32'd1);
        check("lat_e1_addr", 32'(mem_rd_addr_a), 32'd0);
        tick(1);
        check("lat_e2_rd_ptr_gray", 32'(rd_ptr_gray_a), 32'd1);
        check("lat_e2_out_valid", 32'(out_valid_a), 32'd0);
        check("lat_e2_rd_en", 32'(mem_rd_en_a), 32'd0);
        tick(1);
        check("lat_e3_out_valid", 32'(out_valid_a), 32'd1);
        check("lat_e3_out_data", 32'(out_data_a), 32'hA5);
        check("lat_e3_fifo_empty", 32'(fifo_empty_a), 32'd0);
        check("lat_e3_almost_empty", 32'(almost_empty_a), 32'd1);
        out_ready_a = 1'b1;
        tick(1);
        check("pop_fifo_empty", 32'(fifo_empty_a), 32'd1);
        check("pop_out_valid", 32'(out_valid_a), 32'd0);
        check("pop_sb_a", 32'(q_a.size()), 32'd0);

        // 3: backpressure then full-rate drain
        out_ready_a = 1'b0;
        base = rd_en_a;
        for (int i = 0; i < 10; i++) begin
            write_a(8'(8'h30 + i));
            tick(1);
        end
        tick(15);
        check("bp_rd_en_count", 32'(rd_en_a - base), 32'd2);
        check("bp_rd_level", 32'(rd_level_a), 32'd10);
        check("bp_out_valid", 32'(out_valid_a), 32'd1);
        check("bp_out_data", 32'(out_data_a), 32'(q_a[0]));
        check("bp_almost_empty", 32'(almost_empty_a), 32'd0);
        out_ready_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_thru_valid", 32'(out_valid_a), 32'd1);
            tick(1);
        end
        check("bp_sb_a", 32'(q_a.size()), 32'd0);
        check("bp_fifo_empty", 32'(fifo_empty_a), 32'd1);

        // 4: P=4 streaming with pointer wrap
        out_ready_b = 1'b1;
        pb0 = pops_b;
        for (int i = 0; i < 100; i++) begin
            write_b(8'(i * 7 + 3));
            tick(1);
        end
        for (int i = 0; i < 50 && q_b.size() != 0; i++) tick(1);
        check("wrap_sb_b", 32'(q_b.size()), 32'd0);
        check("wrap_pops", 32'(pops_b - pb0), 32'd100);
        check("wrap_rate", 32'(last_pop_b - first_pop_b), 32'd99);
        check("wrap_count", 32'(wraps_b), 32'd3);
        tick(2);
        check("wrap_fifo_empty", 32'(fifo_empty_b), 32'd1);

        // 5: P=4 full RAM plus full buffer
        out_ready_b = 1'b0;
        base = rd_en_b;
        for (int i = 0; i < 16; i++) begin
            write_b(8'(8'hC0 + i));
            tick(1);
        end
        tick(10);
        check("full_rd_level16", 32'(rd_level_b), 32'd16);
        check("full_rd_en_count", 32'(rd_en_b - base), 32'd2);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (5'(wp_b - g2b_b(rd_ptr_gray_b)) < 5'd16) begin
                write_b(8'(8'hE0 + n));
                n++;
            end
            tick(1);
        end
        check("full_refill", 32'(n), 32'd2);
        check("full_rd_level18", 32'(rd_level_b), 32'd18);
        check("full_almost_empty", 32'(almost_empty_b), 32'd0);
        check("full_rd_en_total", 32'(rd_en_b - base), 32'd2);
        out_ready_b = 1'b1;
        for (int i = 0; i < 60 && q_b.size() != 0; i++) tick(1);
        tick(2);
        check("full_sb_b", 32'(q_b.size()), 32'd0);
        check("full_fifo_empty", 32'(fifo_empty_b), 32'd1);

        // 6: asynchronous reset in the middle of a stream
        out_ready_a = 1'b0;
        out_ready_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            write_a(8'(8'h50 + i));
            tick(1);
        end
        tick(6);
        check("mid_pre_out_valid", 32'(out_valid_a), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_out_valid", 32'(out_valid_a), 32'd0);
        check("mid_rd_ptr_gray", 32'(rd_ptr_gray_a), 32'd0);
        check("mid_rd_level", 32'(rd_level_a), 32'd0);
        check("mid_b_rd_ptr_gray", 32'(rd_ptr_gray_b), 32'd0);
        wp_a = '0; wr_ptr_gray_a = '0; q_a.delete();
        wp_b = '0; wr_ptr_gray_b = '0; q_b.delete();
        tick(2);
        reset_n = 1'b1;
        base = rd_en_a;
        n = rd_en_b;
        tick(20);
        check("post_rst_rd_en_a", 32'(rd_en_a - base), 32'd0);
        check("post_rst_rd_en_b", 32'(rd_en_b - n), 32'd0);
        check("post_rst_out_valid", 32'(out_valid_a), 32'd0);
        check("post_rst_fifo_empty", 32'(fifo_empty_a), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
